// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar serial reporting stage: FSM state
// encoding, ASCII constants for the "aaa,ddd#" frame and a digit helper.
package sonar_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_CARREGA   = 4'd1,
    ST_TRANSMITE = 4'd2,
    ST_PROXIMO   = 4'd3,
    ST_FIM       = 4'd4
  } estado_t;

  localparam logic [6:0] ASCII_ZERO    = 7'h30;
  localparam logic [6:0] ASCII_VIRGULA = 7'h2C;
  localparam logic [6:0] ASCII_HASH    = 7'h23;

  localparam int FRAME_LEN = 8;

  // BCD digit to 7-bit ASCII; digits above 9 pass straight through (0xA -> ':')
  function automatic logic [6:0] bcd_to_ascii(input logic [3:0] digito);
    return ASCII_ZERO + {3'b000, digito};
  endfunction

endpackage

// File: rtl/sonar_tx_medida_if.sv
// Measurement-in / UART-out bundle of the sonar reporting stage.
// master = sonar control unit side, slave = sonar_tx_medida.
interface sonar_tx_medida_if;

  logic        partida;
  logic [11:0] angulo;
  logic [11:0] distancia;
  logic        saida_serial;
  logic        pronto;
  logic        ocupado;
  logic [3:0]  db_estado;
  logic [2:0]  db_caractere;

  modport master (
    output partida, angulo, distancia,
    input  saida_serial, pronto, ocupado, db_estado, db_caractere
  );

  modport slave (
    input  partida, angulo, distancia,
    output saida_serial, pronto, ocupado, db_estado, db_caractere
  );

endinterface

// File: rtl/tx_serial_7O1.sv
// Single-character UART transmitter, 7 data bits, odd parity, 1 stop bit.
// A partida pulse while idle loads one character; pronto is high during the
// last cycle of the stop bit so the caller can react on the same edge that
// ends the character.
module tx_serial_7O1 #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [6:0] dados,
  output logic       saida_serial,
  output logic       pronto
);

  localparam int                TICK_W    = $clog2(BAUD_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BAUD_DIV - 1);
  localparam logic [3:0]        BIT_LAST  = 4'd9;

  logic              busy_q,  busy_d;
  logic [TICK_W-1:0] tick_q,  tick_d;
  logic [3:0]        bit_q,   bit_d;
  logic [8:0]        shift_q, shift_d;   // {stop, parity, data[6:0]} still to send
  logic              line_q,  line_d;
  logic              fim_bit;

  assign fim_bit      = busy_q && (tick_q == TICK_LAST);
  assign pronto       = fim_bit && (bit_q == BIT_LAST);
  assign saida_serial = line_q;

  // Next state: load on partida, advance one bit every BAUD_DIV ticks
  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves it unassigned (no latch).
    busy_d  = busy_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    line_d  = line_q;
    if (!busy_q) begin
      if (partida) begin
        busy_d  = 1'b1;
        tick_d  = '0;
        bit_d   = '0;
        shift_d = {1'b1, ~^dados, dados};
        line_d  = 1'b0;                     // start bit
      end
    end else if (fim_bit) begin
      tick_d = '0;
      if (bit_q == BIT_LAST) begin
        busy_d = 1'b0;
        line_d = 1'b1;                      // back to idle level
      end else begin
        bit_d   = bit_q + 4'd1;
        line_d  = shift_q[0];
        shift_d = {1'b1, shift_q[8:1]};
      end
    end else begin
      tick_d = tick_q + 1'b1;
    end
  end

  // State registers with synchronous reset; the line idles high
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (reset) begin
      busy_q  <= 1'b0;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      line_q  <= 1'b1;
    end else begin
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
    end
  end

endmodule

// File: rtl/sonar_tx_medida.sv
// Sonar reporting stage: latches one angle/distance measurement and sends it
// as the ASCII frame "aaa,ddd#" through tx_serial_7O1, one character at a time.
module sonar_tx_medida
  import sonar_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic               clock,
  input  logic               reset,
  sonar_tx_medida_if.slave   bus
);

  localparam logic [2:0] INDICE_ULTIMO = 3'(FRAME_LEN - 1);

  estado_t     estado_q, estado_d;
  logic [11:0] angulo_q, angulo_d;
  logic [11:0] distancia_q, distancia_d;
  logic [2:0]  indice_q, indice_d;
  logic [6:0]  caractere;
  logic        tx_partida;
  logic        tx_pronto;
  logic        tx_linha;
  logic        pronto;
  logic        ocupado;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) estado_q <= ST_IDLE;
    else       estado_q <= estado_d;
  end

  // FSM next state; unused codes fall back to IDLE
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ST_IDLE:      if (bus.partida) estado_d = ST_CARREGA;
      ST_CARREGA:   estado_d = ST_TRANSMITE;
      ST_TRANSMITE: if (tx_pronto) estado_d = ST_PROXIMO;
      ST_PROXIMO:   estado_d = (indice_q == INDICE_ULTIMO) ? ST_FIM : ST_CARREGA;
      ST_FIM:       estado_d = ST_IDLE;
      default:      estado_d = ST_IDLE;
    endcase
  end

  // FSM outputs; ocupado is already low in FIM, the cycle pronto pulses
  always_comb begin
    tx_partida = 1'b0;
    pronto     = 1'b0;
    ocupado    = 1'b0;
    case (estado_q)
      ST_CARREGA:   begin tx_partida = 1'b1; ocupado = 1'b1; end
      ST_TRANSMITE: ocupado = 1'b1;
      ST_PROXIMO:   ocupado = 1'b1;
      ST_FIM:       pronto  = 1'b1;
      default:      ;
    endcase
  end

  // Operand capture on acceptance and character index stepping
  always_comb begin
    angulo_d    = angulo_q;
    distancia_d = distancia_q;
    indice_d    = indice_q;
    if (estado_q == ST_IDLE && bus.partida) begin
      angulo_d    = bus.angulo;
      distancia_d = bus.distancia;
      indice_d    = '0;
    end else if (estado_q == ST_PROXIMO && indice_q != INDICE_ULTIMO) begin
      indice_d = indice_q + 3'd1;
    end
  end

  // Operand and index registers
  always_ff @(posedge clock) begin
    if (reset) begin
      angulo_q    <= '0;
      distancia_q <= '0;
      indice_q    <= '0;
    end else begin
      angulo_q    <= angulo_d;
      distancia_q <= distancia_d;
      indice_q    <= indice_d;
    end
  end

  // Character mux for the current frame position
  always_comb begin
    caractere = ASCII_HASH;
    case (indice_q)
      3'd0:    caractere = bcd_to_ascii(angulo_q[11:8]);
      3'd1:    caractere = bcd_to_ascii(angulo_q[7:4]);
      3'd2:    caractere = bcd_to_ascii(angulo_q[3:0]);
      3'd3:    caractere = ASCII_VIRGULA;
      3'd4:    caractere = bcd_to_ascii(distancia_q[11:8]);
      3'd5:    caractere = bcd_to_ascii(distancia_q[7:4]);
      3'd6:    caractere = bcd_to_ascii(distancia_q[3:0]);
      default: caractere = ASCII_HASH;
    endcase
  end

  tx_serial_7O1 #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clock        (clock),
    .reset        (reset),
    .partida      (tx_partida),
    .dados        (caractere),
    .saida_serial (tx_linha),
    .pronto       (tx_pronto)
  );

  assign bus.saida_serial = tx_linha;
  assign bus.pronto       = pronto;
  assign bus.ocupado      = ocupado;
  assign bus.db_estado    = estado_q;
  assign bus.db_caractere = indice_q;

endmodule
